// File: rtl/can_error_frame_tx.sv
// CAN error frame transmitter: error flag, superposition wait, delimiter and intermission,
// launched by the receive-path checkers and clocked on the bit-time sample point.
module can_error_frame_tx #(
   parameter int FLAG_LEN  = 6,
   parameter int DELIM_LEN = 8,
   parameter int INTER_LEN = 3,
   parameter int DOM_LIMIT = 14
) (
   input  logic       SP,
   input  logic       reset,
   input  logic       RX,
   input  logic       FORM_Error,
   input  logic       CRC_Error,
   input  logic       STUFF_Error,
   input  logic       ERR_PASSIVE,
   output logic       TX,
   output logic       EF_BUSY,
   output logic       EF_DONE,
   output logic [2:0] ERR_SRC,
   output logic       BIT_ERR,
   output logic       DELIM_ERR,
   output logic       OVLD_ERR
);

   // state    | meaning
   // IDLE     | bus recessive, waiting for an error request
   // FLAG     | sending the error flag (dominant if active, recessive if passive)
   // WAIT_REC | flag done, waiting for other nodes' flags to release the bus
   // DELIM    | counting recessive delimiter bits
   // INTER    | intermission before returning to IDLE
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FLAG     = 3'd1,
      S_WAIT_REC = 3'd2,
      S_DELIM    = 3'd3,
      S_INTER    = 3'd4
   } state_t;

   localparam int M_A    = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
   localparam int M_B    = (INTER_LEN > DOM_LIMIT) ? INTER_LEN : DOM_LIMIT;
   localparam int MAXLEN = (M_A > M_B) ? M_A : M_B;
   localparam int CW     = ($clog2(MAXLEN + 1) < 4) ? 4 : $clog2(MAXLEN + 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_tx;
   logic            r_busy;
   logic            r_done;
   logic [2:0]      r_src;
   logic            r_bit_err;
   logic            r_delim_err;
   logic            r_ovld_err;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_tx_nxt;
   logic            w_done_nxt;
   logic [2:0]      w_src_nxt;
   logic            w_bit_err_nxt;
   logic            w_delim_err_nxt;
   logic            w_ovld_err_nxt;
   logic            w_any_err;

   assign w_any_err = ~(FORM_Error & CRC_Error & STUFF_Error);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_tx_nxt        = 1'b1;
      w_done_nxt      = 1'b0;
      w_src_nxt       = r_src;
      w_bit_err_nxt   = 1'b0;
      w_delim_err_nxt = 1'b0;
      w_ovld_err_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_err) begin
               w_state_nxt = S_FLAG;
               w_cnt_nxt   = '0;
               w_tx_nxt    = ERR_PASSIVE;
               w_src_nxt   = ~{FORM_Error, CRC_Error, STUFF_Error};
            end
         end
         S_FLAG: begin
            // r_tx low means the bit just sampled was one we drove dominant
            w_bit_err_nxt = ~r_tx & RX;
            if (r_cnt == CW'(FLAG_LEN - 1)) begin
               w_state_nxt = S_WAIT_REC;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               w_tx_nxt  = ERR_PASSIVE;
            end
         end
         S_WAIT_REC: begin
            if (RX) begin
               w_state_nxt = S_DELIM;
               w_cnt_nxt   = CW'(1);
            end else if (r_cnt == CW'(DOM_LIMIT - 1)) begin
               w_ovld_err_nxt = 1'b1;
               w_cnt_nxt      = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DELIM: begin
            if (!RX) begin
               w_delim_err_nxt = 1'b1;
               w_state_nxt     = S_FLAG;
               w_cnt_nxt       = '0;
               w_tx_nxt        = ERR_PASSIVE;
            end else if (r_cnt == CW'(DELIM_LEN - 1)) begin
               w_state_nxt = S_INTER;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_INTER: begin
            if (r_cnt == CW'(INTER_LEN - 1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge SP or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_src       <= 3'b000;
         r_bit_err   <= 1'b0;
         r_delim_err <= 1'b0;
         r_ovld_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tx        <= w_tx_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= w_done_nxt;
         r_src       <= w_src_nxt;
         r_bit_err   <= w_bit_err_nxt;
         r_delim_err <= w_delim_err_nxt;
         r_ovld_err  <= w_ovld_err_nxt;
      end
   end

   assign TX        = r_tx;
   assign EF_BUSY   = r_busy;
   assign EF_DONE   = r_done;
   assign ERR_SRC   = r_src;
   assign BIT_ERR   = r_bit_err;
   assign DELIM_ERR = r_delim_err;
   assign OVLD_ERR  = r_ovld_err;

endmodule

// File: tb/tb_can_error_frame_tx.sv
// Scoreboard bench for can_error_frame_tx: expected output vectors
// {TX,EF_BUSY,EF_DONE,ERR_SRC,BIT_ERR,DELIM_ERR,OVLD_ERR} are queued per SP edge.
module tb_can_error_frame_tx;

   logic       SP;
   logic       reset;
   logic       RX;
   logic       FORM_Error;
   logic       CRC_Error;
   logic       STUFF_Error;
   logic       ERR_PASSIVE;
   logic       TX;
   logic       EF_BUSY;
   logic       EF_DONE;
   logic [2:0] ERR_SRC;
   logic       BIT_ERR;
   logic       DELIM_ERR;
   logic       OVLD_ERR;

   int         n_chk;
   int         n_err;
   logic [8:0] exp_q[$];

   can_error_frame_tx dut (
      .SP          (SP),
      .reset       (reset),
      .RX          (RX),
      .FORM_Error  (FORM_Error),
      .CRC_Error   (CRC_Error),
      .STUFF_Error (STUFF_Error),
      .ERR_PASSIVE (ERR_PASSIVE),
      .TX          (TX),
      .EF_BUSY     (EF_BUSY),
      .EF_DONE     (EF_DONE),
      .ERR_SRC     (ERR_SRC),
      .BIT_ERR     (BIT_ERR),
      .DELIM_ERR   (DELIM_ERR),
      .OVLD_ERR    (OVLD_ERR)
   );

   initial SP = 1'b0;
   always #5 SP = ~SP;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
      $fatal(1);
   end

   localparam logic [8:0] IDLE_VEC = 9'b1_0_0_000_000;

   task automatic test_reset();
      logic [8:0] g;
      reset = 1'b1; RX = 1'b1; FORM_Error = 1'b0; CRC_Error = 1'b1;
      STUFF_Error = 1'b1; ERR_PASSIVE = 1'b0;
      #1;
      exp_q.push_back(IDLE_VEC);
      g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
      n_chk++;
      if (g !== exp_q.pop_front()) begin
         n_err++; $display("FAIL reset_initial: got %b required %b", g, IDLE_VEC);
      end
      exp_q.push_back(IDLE_VEC);
      @(posedge SP); #1;
      g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
      n_chk++;
      if (g !== exp_q.pop_front()) begin
         n_err++; $display("FAIL reset_held_edge: got %b required %b", g, IDLE_VEC);
      end
      FORM_Error = 1'b1;
      #2 reset = 1'b0;
   endtask

   task automatic test_form_active();
      logic [8:0] e, g;
      logic rx_m;
      rx_m = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         FORM_Error = (k == 0) ? 1'b0 : 1'b1; ERR_PASSIVE = 1'b0; RX = rx_m;
         e = {(k <= 5) ? 1'b0 : 1'b1, k <= 16, k == 17, 3'b100, 3'b000};
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL form_active E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   task automatic test_passive_crc_stuff();
      logic [8:0] e, g;
      for (int k = 0; k <= 18; k++) begin
         CRC_Error = (k == 0) ? 1'b0 : 1'b1; STUFF_Error = (k == 0) ? 1'b0 : 1'b1;
         ERR_PASSIVE = 1'b1; RX = 1'b1;
         e = {1'b1, k <= 16, k == 17, 3'b011, 3'b000};
         exp_q.push_back(e);
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL passive_crc_stuff E%0d: got %b required %b", k, g, e);
         end
      end
      ERR_PASSIVE = 1'b0;
   endtask

   task automatic test_bit_err();
      logic [8:0] e, g;
      logic rx_m;
      rx_m = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         FORM_Error = (k == 0) ? 1'b0 : 1'b1;
         RX = (k == 2 || k == 4) ? 1'b1 : rx_m;
         e = {(k <= 5) ? 1'b0 : 1'b1, k <= 16, k == 17, 3'b100, (k == 2 || k == 4), 2'b00};
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL bit_err E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   task automatic test_superposition();
      logic [8:0] e, g;
      for (int k = 0; k <= 22; k++) begin
         CRC_Error = (k == 0) ? 1'b0 : 1'b1;
         RX = (k >= 1 && k <= 10) ? 1'b0 : 1'b1;
         e = {(k <= 5) ? 1'b0 : 1'b1, k <= 20, k == 21, 3'b010, 3'b000};
         exp_q.push_back(e);
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL superposition E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   task automatic test_overload();
      logic [8:0] e, g;
      for (int k = 0; k <= 32; k++) begin
         FORM_Error = (k == 0) ? 1'b0 : 1'b1;
         RX = (k >= 1 && k <= 20) ? 1'b0 : 1'b1;
         e = {(k <= 5) ? 1'b0 : 1'b1, k <= 30, k == 31, 3'b100, 2'b00, k == 20};
         exp_q.push_back(e);
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL overload E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   task automatic test_delim_err();
      logic [8:0] e, g;
      logic rx_m;
      rx_m = 1'b1;
      for (int k = 0; k <= 28; k++) begin
         STUFF_Error = (k == 0) ? 1'b0 : 1'b1;
         RX = (k == 10) ? 1'b0 : rx_m;
         e = {(k <= 5 || (k >= 10 && k <= 15)) ? 1'b0 : 1'b1, k <= 26, k == 27,
              3'b001, 1'b0, k == 10, 1'b0};
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL delim_err E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   // Errors requested mid-frame are ignored; STUFF held low is taken at E18.
   task automatic test_back_to_back();
      logic [8:0] e, g;
      logic rx_m;
      int j;
      rx_m = 1'b1;
      for (int k = 0; k <= 36; k++) begin
         FORM_Error  = (k == 0 || k == 17) ? 1'b0 : 1'b1;
         STUFF_Error = (k >= 1 && k <= 18) ? 1'b0 : 1'b1;
         RX = rx_m;
         if (k < 18)
            e = {(k <= 5) ? 1'b0 : 1'b1, k <= 16, k == 17, 3'b100, 3'b000};
         else begin
            j = k - 18;
            e = {(j <= 5) ? 1'b0 : 1'b1, j <= 16, j == 17, 3'b001, 3'b000};
         end
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL back_to_back E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   task automatic test_reset_mid_flag();
      logic [8:0] e, g;
      logic rx_m;
      rx_m = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         FORM_Error = (k == 0) ? 1'b0 : 1'b1; RX = rx_m;
         e = {1'b0, 1'b1, 1'b0, 3'b100, 3'b000};
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL reset_mid_flag E%0d: got %b required %b", k, g, e);
         end
      end
      #3 reset = 1'b1;
      #1;
      exp_q.push_back(IDLE_VEC);
      g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin
         n_err++; $display("FAIL reset_async_abort: got %b required %b", g, e);
      end
      RX = 1'b1;
      exp_q.push_back(IDLE_VEC);
      @(posedge SP); #1;
      g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin
         n_err++; $display("FAIL reset_hold_E3: got %b required %b", g, e);
      end
      #2 reset = 1'b0;
      rx_m = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         FORM_Error = (k == 0) ? 1'b0 : 1'b1; RX = rx_m;
         e = {(k <= 5) ? 1'b0 : 1'b1, k <= 16, k == 17, 3'b100, 3'b000};
         exp_q.push_back(e);
         rx_m = e[8];
         @(posedge SP); #1;
         e = exp_q.pop_front();
         g = {TX, EF_BUSY, EF_DONE, ERR_SRC, BIT_ERR, DELIM_ERR, OVLD_ERR};
         n_chk++;
         if (g !== e) begin
            n_err++; $display("FAIL restart_after_reset E%0d: got %b required %b", k, g, e);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      test_reset();
      @(posedge SP); #1;
      test_form_active();
      test_passive_crc_stuff();
      test_bit_err();
      test_superposition();
      test_overload();
      test_delim_err();
      test_back_to_back();
      test_reset_mid_flag();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
